// File: rtl/exmem_skid_reg_pkg.sv
// EX/MEM skid register shared definitions.
// Control field layout, flag layout and occupancy encoding.
package exmem_skid_reg_pkg;

  localparam int CWIDTH = 10;
  localparam int FWIDTH = 3;

  localparam int C_REGWR  = 0;
  localparam int C_MTR_LO = 1;
  localparam int C_MTR_HI = 2;
  localparam int C_MEMWR  = 3;
  localparam int C_MEMRD  = 4;
  localparam int C_BBNE   = 5;
  localparam int C_BBEQ   = 6;
  localparam int C_BBLEZ  = 7;
  localparam int C_BBGTZ  = 8;
  localparam int C_JUMP   = 9;

  localparam int F_ZERO = 0;
  localparam int F_NEG  = 1;
  localparam int F_OVF  = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/exmem_skid_reg_branch_resolve.sv
// Branch/jump resolution on the EX/MEM head entry.
// Jump takes precedence over a taken branch.
module branch_resolve #(
  parameter int AWIDTH = 32
) (
  input  logic              valid,
  input  logic              jump,
  input  logic              bbeq,
  input  logic              bbne,
  input  logic              bblez,
  input  logic              bbgtz,
  input  logic              zero,
  input  logic              negative,
  input  logic [AWIDTH-1:0] branaddr,
  input  logic [AWIDTH-1:0] jmpaddr,
  output logic              redirect,
  output logic [AWIDTH-1:0] redirect_addr
);

  logic taken;

  always_comb begin
    taken = (bbeq  & zero)
          | (bbne  & ~zero)
          | (bblez & (zero | negative))
          | (bbgtz & ~zero & ~negative);
    redirect      = valid & (jump | taken);
    redirect_addr = jump ? jmpaddr : branaddr;
  end

endmodule

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// in_ready is registered so MEM back-pressure never reaches EX combinationally.
module exmem_skid_reg
  import exmem_skid_reg_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CWIDTH-1:0] in_ctrl,
  input  logic [DWIDTH-1:0] in_alu,
  input  logic [2:0]        in_flags,
  input  logic [RWIDTH-1:0] in_rd,
  input  logic [RWIDTH-1:0] in_rt,
  input  logic [DWIDTH-1:0] in_data2,
  input  logic [AWIDTH-1:0] in_branaddr,
  input  logic [AWIDTH-1:0] in_jmpaddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] out_ctrl,
  output logic [DWIDTH-1:0] out_alu,
  output logic [2:0]        out_flags,
  output logic [RWIDTH-1:0] out_rd,
  output logic [RWIDTH-1:0] out_rt,
  output logic [DWIDTH-1:0] out_data2,
  output logic [AWIDTH-1:0] out_branaddr,
  output logic [AWIDTH-1:0] out_jmpaddr,
  output logic              redirect,
  output logic [AWIDTH-1:0] redirect_addr,
  output logic              fwd_valid,
  output logic [RWIDTH-1:0] fwd_rd,
  output logic [DWIDTH-1:0] fwd_data
);

  occ_e state_q, state_d;
  logic accept;
  logic load_head, pop_skid, load_skid;
  logic ready_d;

  logic [CWIDTH-1:0] h_ctrl, s_ctrl;
  logic [DWIDTH-1:0] h_alu, s_alu;
  logic [2:0]        h_flags, s_flags;
  logic [RWIDTH-1:0] h_rd, s_rd;
  logic [RWIDTH-1:0] h_rt, s_rt;
  logic [DWIDTH-1:0] h_data2, s_data2;
  logic [AWIDTH-1:0] h_bra, s_bra;
  logic [AWIDTH-1:0] h_jmp, s_jmp;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !out_ready) state_d = S_TWO;
        else if (!accept && out_ready) state_d = S_EMPTY;
      end
      S_TWO: if (out_ready) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    ready_d   = (state_d != S_TWO);
    load_head = 1'b0;
    pop_skid  = 1'b0;
    load_skid = 1'b0;
    if (!flush) begin
      unique case (1'b1)
        state_q == S_EMPTY: load_head = accept;
        state_q == S_ONE: begin
          load_head = accept & out_ready;
          load_skid = accept & ~out_ready;
        end
        state_q == S_TWO: pop_skid = out_ready;
        default: ;
      endcase
    end
  end

  // Payload regs carry no valid bit; occupancy lives in state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_ctrl  <= '0; h_alu <= '0; h_flags <= '0; h_rd  <= '0;
      h_rt    <= '0; h_data2 <= '0; h_bra <= '0; h_jmp <= '0;
      s_ctrl  <= '0; s_alu <= '0; s_flags <= '0; s_rd  <= '0;
      s_rt    <= '0; s_data2 <= '0; s_bra <= '0; s_jmp <= '0;
    end else begin
      if (load_head) begin
        h_ctrl  <= in_ctrl;  h_alu   <= in_alu;
        h_flags <= in_flags; h_rd    <= in_rd;
        h_rt    <= in_rt;    h_data2 <= in_data2;
        h_bra   <= in_branaddr;
        h_jmp   <= in_jmpaddr;
      end else if (pop_skid) begin
        h_ctrl  <= s_ctrl;  h_alu   <= s_alu;
        h_flags <= s_flags; h_rd    <= s_rd;
        h_rt    <= s_rt;    h_data2 <= s_data2;
        h_bra   <= s_bra;   h_jmp   <= s_jmp;
      end
      if (load_skid) begin
        s_ctrl  <= in_ctrl;  s_alu   <= in_alu;
        s_flags <= in_flags; s_rd    <= in_rd;
        s_rt    <= in_rt;    s_data2 <= in_data2;
        s_bra   <= in_branaddr;
        s_jmp   <= in_jmpaddr;
      end
    end
  end

  assign out_ctrl     = out_valid ? h_ctrl : '0;
  assign out_alu      = h_alu;
  assign out_flags    = h_flags;
  assign out_rd       = h_rd;
  assign out_rt       = h_rt;
  assign out_data2    = h_data2;
  assign out_branaddr = h_bra;
  assign out_jmpaddr  = h_jmp;

  assign fwd_valid = out_valid & h_ctrl[C_REGWR] & (h_rd != '0);
  assign fwd_rd    = h_rd;
  assign fwd_data  = h_alu;

  branch_resolve #(
    .AWIDTH(AWIDTH)
  ) u_br (
    .valid        (out_valid),
    .jump         (h_ctrl[C_JUMP]),
    .bbeq         (h_ctrl[C_BBEQ]),
    .bbne         (h_ctrl[C_BBNE]),
    .bblez        (h_ctrl[C_BBLEZ]),
    .bbgtz        (h_ctrl[C_BBGTZ]),
    .zero         (h_flags[F_ZERO]),
    .negative     (h_flags[F_NEG]),
    .branaddr     (h_bra),
    .jmpaddr      (h_jmp),
    .redirect     (redirect),
    .redirect_addr(redirect_addr)
  );

endmodule
